// File: rtl/atm_pkg.sv
// Shared encodings for the ATM transaction engine: op codes, response status codes, FSM states.
package atm_pkg;

  typedef enum logic [2:0] {
    OP_BALANCE    = 3'd0,
    OP_WITHDRAW   = 3'd1,
    OP_DEPOSIT    = 3'd2,
    OP_CHANGE_PIN = 3'd3,
    OP_UNLOCK     = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_OK      = 3'd0,
    ST_BAD_ACC = 3'd1,
    ST_BAD_PIN = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_INSUF   = 3'd4,
    ST_OVFL    = 3'd5,
    ST_LIMIT   = 3'd6,
    ST_BAD_OP  = 3'd7
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_EXEC  = 3'd2,
    S_RESP  = 3'd3
  } state_e;

  function automatic logic op_defined(input logic [2:0] op);
    return op <= OP_UNLOCK;
  endfunction

endpackage

// File: rtl/atm_pin_guard.sv
// Per-account PIN store with consecutive-failure counters and lock bits.
module atm_pin_guard #(
  parameter int unsigned       NUM_ACC   = 16,
  parameter int unsigned       PIN_W     = 16,
  parameter int unsigned       MAX_TRIES = 3,
  parameter logic [PIN_W-1:0]  INIT_PIN  = 16'h1234,
  parameter int unsigned       ACC_W     = $clog2(NUM_ACC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] acc,
  input  logic [PIN_W-1:0] pin,
  input  logic [PIN_W-1:0] new_pin,
  input  logic             fail_stb,
  input  logic             pass_stb,
  input  logic             unlock_stb,
  input  logic             pin_wr_stb,
  output logic             match,
  output logic             locked
);

  localparam int unsigned CNT_W = $clog2(MAX_TRIES + 1);

  logic [PIN_W-1:0] pins  [NUM_ACC];
  logic [CNT_W-1:0] tries [NUM_ACC];
  logic             lock  [NUM_ACC];

  assign match  = (pin == pins[acc]);
  assign locked = lock[acc];

  // NOTE: the account tables are flop arrays, not RAM, so they can and must be reset element by element.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        pins[i]  <= INIT_PIN;
        tries[i] <= '0;
        lock[i]  <= 1'b0;
      end
    end else begin
      if (pin_wr_stb) pins[acc] <= new_pin;
      if (unlock_stb || pass_stb) tries[acc] <= '0;
      if (unlock_stb) begin
        lock[acc] <= 1'b0;
      end else if (fail_stb) begin
        // Counter saturates at MAX_TRIES; the lock is set on the failure that reaches it.
        if (tries[acc] < CNT_W'(MAX_TRIES)) tries[acc] <= tries[acc] + CNT_W'(1);
        if (tries[acc] >= CNT_W'(MAX_TRIES - 1)) lock[acc] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/atm_txn_engine.sv
// ATM transaction engine: IDLE->CHECK->EXEC->RESP pipeline over a per-account balance table.
// Optional per-account daily withdraw limit enabled by defining ATM_DAILY_LIMIT_EN.
module atm_txn_engine
  import atm_pkg::*;
#(
  parameter int unsigned      NUM_ACC   = 16,
  parameter int unsigned      BAL_W     = 32,
  parameter int unsigned      PIN_W     = 16,
  parameter int unsigned      MAX_TRIES = 3,
  parameter int unsigned      INIT_BAL  = 1000,
  parameter logic [PIN_W-1:0] INIT_PIN  = 16'h1234,
  parameter int unsigned      WD_LIMIT  = 5000,
  localparam int unsigned     ACC_W     = $clog2(NUM_ACC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       op,
  input  logic [ACC_W-1:0] acc_num,
  input  logic [PIN_W-1:0] pin,
  input  logic [PIN_W-1:0] new_pin,
  input  logic [BAL_W-1:0] amount,
  input  logic             day_clr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_status,
  output logic [BAL_W-1:0] balance,
  output logic [2:0]       state
);

  state_e           cur_state, nxt_state;
  logic [2:0]       op_q;
  logic [ACC_W-1:0] acc_q;
  logic [PIN_W-1:0] pin_q, new_pin_q;
  logic [BAL_W-1:0] amount_q;
  status_e          chk_q, chk_d, res_status, rsp_status_q;
  logic [BAL_W-1:0] bal_mem [NUM_ACC];
  logic [BAL_W-1:0] cur_bal, new_bal, res_bal, balance_q;
  logic [BAL_W:0]   dep_sum;
  logic             acc_ok, exec, match, locked;
  logic [ACC_W-1:0] acc_idx;
  logic             bal_wr, fail_stb, pass_stb, unlock_stb, pin_wr_stb;

  assign state      = cur_state;
  assign rsp_status = rsp_status_q;
  assign balance    = balance_q;
  assign exec       = (cur_state == S_EXEC);
  assign acc_ok     = (32'(acc_q) < NUM_ACC);
  // Out-of-range accounts are steered to index 0 so table reads stay in bounds; nothing is written for them.
  assign acc_idx    = acc_ok ? acc_q : '0;
  assign cur_bal    = bal_mem[acc_idx];
  assign dep_sum    = {1'b0, cur_bal} + {1'b0, amount_q};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nxt_state = cur_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (cur_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) nxt_state = S_CHECK;
      end
      S_CHECK: nxt_state = S_EXEC;
      S_EXEC:  nxt_state = S_RESP;
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur_state <= S_IDLE;
    else      cur_state <= nxt_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= '0;
      acc_q     <= '0;
      pin_q     <= '0;
      new_pin_q <= '0;
      amount_q  <= '0;
    end else if (cur_state == S_IDLE && req_valid) begin
      op_q      <= op;
      acc_q     <= acc_num;
      pin_q     <= pin;
      new_pin_q <= new_pin;
      amount_q  <= amount;
    end
  end

  atm_pin_guard #(
    .NUM_ACC  (NUM_ACC),
    .PIN_W    (PIN_W),
    .MAX_TRIES(MAX_TRIES),
    .INIT_PIN (INIT_PIN),
    .ACC_W    (ACC_W)
  ) u_pin_guard (
    .clk       (clk),
    .rst       (rst),
    .acc       (acc_idx),
    .pin       (pin_q),
    .new_pin   (new_pin_q),
    .fail_stb  (fail_stb),
    .pass_stb  (pass_stb),
    .unlock_stb(unlock_stb),
    .pin_wr_stb(pin_wr_stb),
    .match     (match),
    .locked    (locked)
  );

  // UNLOCK is authorised by the supervisor PIN, every other op by the account PIN.
  always_comb begin
    chk_d = ST_OK;
    if (!acc_ok)                                     chk_d = ST_BAD_ACC;
    else if (!op_defined(op_q))                      chk_d = ST_BAD_OP;
    else if (locked && op_q != OP_UNLOCK)            chk_d = ST_LOCKED;
    else if (op_q == OP_UNLOCK ? (pin_q != INIT_PIN) : !match) chk_d = ST_BAD_PIN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     chk_q <= ST_OK;
    else if (cur_state == S_CHECK) chk_q <= chk_d;
  end

`ifdef ATM_DAILY_LIMIT_EN
  logic [BAL_W-1:0] wd_total [NUM_ACC];
  logic [BAL_W:0]   wd_sum;
  logic             wd_add;
  assign wd_sum = {1'b0, wd_total[acc_idx]} + {1'b0, amount_q};
`else
  logic             unused_day_clr;
  logic [BAL_W-1:0] unused_wd_limit;
  assign unused_day_clr  = day_clr;
  assign unused_wd_limit = BAL_W'(WD_LIMIT);
`endif

  always_comb begin
    res_status = chk_q;
    res_bal    = cur_bal;
    new_bal    = cur_bal;
    bal_wr     = 1'b0;
    fail_stb   = 1'b0;
    pass_stb   = 1'b0;
    unlock_stb = 1'b0;
    pin_wr_stb = 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
    wd_add     = 1'b0;
`endif
    unique case (chk_q)
      ST_OK: begin
        pass_stb = exec;
        case (op_q)
          OP_WITHDRAW: begin
            if (amount_q > cur_bal) res_status = ST_INSUF;
`ifdef ATM_DAILY_LIMIT_EN
            else if (wd_sum > (BAL_W+1)'(WD_LIMIT)) res_status = ST_LIMIT;
`endif
            else begin
              new_bal = cur_bal - amount_q;
              bal_wr  = exec;
`ifdef ATM_DAILY_LIMIT_EN
              wd_add  = exec;
`endif
            end
          end
          OP_DEPOSIT: begin
            if (dep_sum[BAL_W]) res_status = ST_OVFL;
            else begin
              new_bal = dep_sum[BAL_W-1:0];
              bal_wr  = exec;
            end
          end
          OP_CHANGE_PIN: pin_wr_stb = exec;
          OP_UNLOCK:     unlock_stb = exec;
          default: ;
        endcase
        res_bal = new_bal;
      end
      ST_BAD_PIN: fail_stb = exec;
      ST_INSUF, ST_OVFL, ST_LIMIT: ;
      default: res_bal = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACC; i++) bal_mem[i] <= BAL_W'(INIT_BAL);
    end else if (bal_wr) begin
      bal_mem[acc_idx] <= new_bal;
    end
  end

`ifdef ATM_DAILY_LIMIT_EN
  // day_clr is written last so it overrides a withdraw commit on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ACC; i++) wd_total[i] <= '0;
    end else begin
      if (wd_add) wd_total[acc_idx] <= wd_sum[BAL_W-1:0];
      if (day_clr) for (int i = 0; i < NUM_ACC; i++) wd_total[i] <= '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_status_q <= ST_OK;
      balance_q    <= '0;
    end else if (exec) begin
      rsp_status_q <= res_status;
      balance_q    <= res_bal;
    end
  end

endmodule

// File: tb/tb_atm_txn_engine.sv
// Directed bench for atm_txn_engine; expectations follow ATM_DAILY_LIMIT_EN when defined.
module tb_atm_txn_engine;
  import atm_pkg::*;

  // NUM_ACC 12 keeps out-of-range account numbers representable on the 4-bit acc_num port.
  localparam int NUM_ACC = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, day_clr;
  logic [2:0]  op, rsp_status, state;
  logic [3:0]  acc_num;
  logic [15:0] pin, new_pin;
  logic [31:0] amount, balance;

  int n_cmp  = 0;
  int n_fail = 0;

  atm_txn_engine #(.NUM_ACC(NUM_ACC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .acc_num   (acc_num),
    .pin       (pin),
    .new_pin   (new_pin),
    .amount    (amount),
    .day_clr   (day_clr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_status(rsp_status),
    .balance   (balance),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge; rsp_valid must be low in CHECK/EXEC and high three cycles after the handshake cycle.
  task automatic do_txn(input string tag, input logic [2:0] t_op, input logic [3:0] t_acc,
                        input logic [15:0] t_pin, input logic [15:0] t_new, input logic [31:0] t_amt,
                        input int stall, input logic [2:0] exp_st, input logic [31:0] exp_bal);
    req_valid = 1'b1;
    op        = t_op;
    acc_num   = t_acc;
    pin       = t_pin;
    new_pin   = t_new;
    amount    = t_amt;
    check({tag, ":req_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, ":valid_c1"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check({tag, ":valid_c2"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check({tag, ":valid_c3"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, ":status"}, {29'd0, rsp_status}, {29'd0, exp_st});
    check({tag, ":balance"}, balance, exp_bal);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ":stall_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, ":stall_status"}, {29'd0, rsp_status}, {29'd0, exp_st});
      check({tag, ":stall_balance"}, balance, exp_bal);
      check({tag, ":stall_req_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ":back_idle"}, {29'd0, state}, {29'd0, S_IDLE});
  endtask

  localparam logic [15:0] P_OK  = 16'h1234;
  localparam logic [15:0] P_BAD = 16'h1111;

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; day_clr = 1'b0;
    op = '0; acc_num = '0; pin = '0; new_pin = '0; amount = '0;
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst:state", {29'd0, state}, {29'd0, S_IDLE});
    check("rst:rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst:status", {29'd0, rsp_status}, {29'd0, ST_OK});
    check("rst:balance", balance, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_txn("wd300_acc2", OP_WITHDRAW, 4'd2, P_OK, 16'h0, 32'd300, 0, ST_OK, 32'd700);

    do_txn("acc5_bad1", OP_WITHDRAW, 4'd5, P_BAD, 16'h0, 32'd1, 0, ST_BAD_PIN, 32'd1000);
    do_txn("acc5_bad2", OP_WITHDRAW, 4'd5, P_BAD, 16'h0, 32'd1, 0, ST_BAD_PIN, 32'd1000);
    do_txn("acc5_bad3", OP_WITHDRAW, 4'd5, P_BAD, 16'h0, 32'd1, 0, ST_BAD_PIN, 32'd1000);
    do_txn("acc5_locked", OP_WITHDRAW, 4'd5, P_OK, 16'h0, 32'd1, 0, ST_LOCKED, 32'd0);
    do_txn("acc5_unlock", OP_UNLOCK, 4'd5, P_OK, 16'h0, 32'd0, 0, ST_OK, 32'd1000);
    do_txn("acc5_wd1", OP_WITHDRAW, 4'd5, P_OK, 16'h0, 32'd1, 0, ST_OK, 32'd999);

    do_txn("acc6_bad1", OP_BALANCE, 4'd6, P_BAD, 16'h0, 32'd0, 0, ST_BAD_PIN, 32'd1000);
    do_txn("acc6_bad2", OP_BALANCE, 4'd6, P_BAD, 16'h0, 32'd0, 0, ST_BAD_PIN, 32'd1000);
    do_txn("acc6_good", OP_BALANCE, 4'd6, P_OK, 16'h0, 32'd0, 0, ST_OK, 32'd1000);
    do_txn("acc6_bad3", OP_BALANCE, 4'd6, P_BAD, 16'h0, 32'd0, 0, ST_BAD_PIN, 32'd1000);
    do_txn("acc6_bad4", OP_BALANCE, 4'd6, P_BAD, 16'h0, 32'd0, 0, ST_BAD_PIN, 32'd1000);
    do_txn("acc6_good2", OP_BALANCE, 4'd6, P_OK, 16'h0, 32'd0, 0, ST_OK, 32'd1000);

    do_txn("acc0_ovfl", OP_DEPOSIT, 4'd0, P_OK, 16'h0, 32'hFFFF_FFFF, 0, ST_OVFL, 32'd1000);
    do_txn("acc0_insuf", OP_WITHDRAW, 4'd0, P_OK, 16'h0, 32'd1001, 0, ST_INSUF, 32'd1000);
    do_txn("acc0_dep0", OP_DEPOSIT, 4'd0, P_OK, 16'h0, 32'd0, 0, ST_OK, 32'd1000);
    do_txn("acc0_wd0", OP_WITHDRAW, 4'd0, P_OK, 16'h0, 32'd0, 0, ST_OK, 32'd1000);
    do_txn("acc0_wd_all", OP_WITHDRAW, 4'd0, P_OK, 16'h0, 32'd1000, 0, ST_OK, 32'd0);
    do_txn("acc0_dep_max", OP_DEPOSIT, 4'd0, P_OK, 16'h0, 32'hFFFF_FFFF, 0, ST_OK, 32'hFFFF_FFFF);

    do_txn("acc1_chpin", OP_CHANGE_PIN, 4'd1, P_OK, 16'h0042, 32'd0, 0, ST_OK, 32'd1000);
    do_txn("acc1_oldpin", OP_BALANCE, 4'd1, P_OK, 16'h0, 32'd0, 0, ST_BAD_PIN, 32'd1000);
    do_txn("acc1_newpin", OP_BALANCE, 4'd1, 16'h0042, 16'h0, 32'd0, 0, ST_OK, 32'd1000);
    do_txn("acc1_samepin", OP_CHANGE_PIN, 4'd1, 16'h0042, 16'h0042, 32'd0, 0, ST_OK, 32'd1000);

    do_txn("bad_op", 3'd5, 4'd3, P_OK, 16'h0, 32'd0, 0, ST_BAD_OP, 32'd0);
    do_txn("bad_acc_first", 3'd5, 4'd13, P_OK, 16'h0, 32'd0, 0, ST_BAD_ACC, 32'd0);
    do_txn("bad_acc_edge", OP_BALANCE, 4'd12, P_OK, 16'h0, 32'd0, 0, ST_BAD_ACC, 32'd0);
    do_txn("last_acc", OP_BALANCE, 4'd11, P_OK, 16'h0, 32'd0, 0, ST_OK, 32'd1000);
    do_txn("unlock_badsup", OP_UNLOCK, 4'd7, P_BAD, 16'h0, 32'd0, 0, ST_BAD_PIN, 32'd1000);

    do_txn("acc3_dep9000", OP_DEPOSIT, 4'd3, P_OK, 16'h0, 32'd9000, 0, ST_OK, 32'd10000);
    do_txn("acc3_wd4000", OP_WITHDRAW, 4'd3, P_OK, 16'h0, 32'd4000, 0, ST_OK, 32'd6000);
`ifdef ATM_DAILY_LIMIT_EN
    do_txn("acc3_wd1500a", OP_WITHDRAW, 4'd3, P_OK, 16'h0, 32'd1500, 0, ST_LIMIT, 32'd6000);
`else
    do_txn("acc3_wd1500a", OP_WITHDRAW, 4'd3, P_OK, 16'h0, 32'd1500, 0, ST_OK, 32'd4500);
`endif
    day_clr = 1'b1;
    @(negedge clk);
    day_clr = 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
    do_txn("acc3_wd1500b", OP_WITHDRAW, 4'd3, P_OK, 16'h0, 32'd1500, 0, ST_OK, 32'd4500);
    do_txn("acc3_wd_to_lim", OP_WITHDRAW, 4'd3, P_OK, 16'h0, 32'd3500, 0, ST_OK, 32'd1000);
`else
    do_txn("acc3_wd1500b", OP_WITHDRAW, 4'd3, P_OK, 16'h0, 32'd1500, 0, ST_OK, 32'd3000);
    do_txn("acc3_wd_to_lim", OP_WITHDRAW, 4'd3, P_OK, 16'h0, 32'd3500, 0, ST_INSUF, 32'd3000);
`endif

    do_txn("stall5", OP_BALANCE, 4'd2, P_OK, 16'h0, 32'd0, 5, ST_OK, 32'd700);

    req_valid = 1'b1;
    op        = OP_WITHDRAW;
    acc_num   = 4'd2;
    pin       = P_OK;
    amount    = 32'd300;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #2;
    check("midrst:state", {29'd0, state}, {29'd0, S_IDLE});
    check("midrst:rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst:balance", balance, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst:rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
    do_txn("post_rst_acc2", OP_BALANCE, 4'd2, P_OK, 16'h0, 32'd0, 0, ST_OK, 32'd1000);
    do_txn("post_rst_acc1_pin", OP_BALANCE, 4'd1, P_OK, 16'h0, 32'd0, 0, ST_OK, 32'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
